// File: rtl/conv2d_stream_layer_if.sv
// rtl/conv2d_stream_layer_if.sv - coefficient, pixel and result streams of one convolution layer
interface conv2d_stream_layer_if #(
    parameter int IN_W  = 4,
    parameter int FLT_W = 4,
    parameter int RES_W = 14
);
    logic             flt_valid;
    logic [FLT_W-1:0] flt_data;
    logic             flt_ready;
    logic             pix_valid;
    logic [IN_W-1:0]  pix_data;
    logic             pix_ready;
    logic             res_valid;
    logic [RES_W-1:0] res_data;
    logic             res_last;
    logic             res_ready;

    modport slave (
        input  flt_valid, flt_data, pix_valid, pix_data, res_ready,
        output flt_ready, pix_ready, res_valid, res_data, res_last
    );

    modport master (
        output flt_valid, flt_data, pix_valid, pix_data, res_ready,
        input  flt_ready, pix_ready, res_valid, res_data, res_last
    );
endinterface

// File: rtl/conv2d_stream_layer.sv
// rtl/conv2d_stream_layer.sv - KxK stride-1 valid convolution over a raster pixel stream
module conv2d_stream_layer #(
    parameter int IN_W      = 4,
    parameter int IN_SIGNED = 0,
    parameter int FLT_W     = 4,
    parameter int K         = 3,
    parameter int IMG_W     = 4,
    parameter int IMG_H     = 4,
    parameter int RES_W     = 14,
    parameter int RELU      = 0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   reuse_flt,
    conv2d_stream_layer_if.slave   bus,
    output logic                   busy,
    output logic                   done
);
    localparam int NC = K * K;
    localparam int PW = IN_W + 1 + FLT_W;
    localparam int SW = PW + $clog2(NC);
    localparam int CW = ((SW > RES_W) ? SW : RES_W) + 1;
    localparam int XW = $clog2(IMG_W);
    localparam int YW = $clog2(IMG_H);
    localparam int NW = $clog2(NC);

    localparam logic [XW-1:0] COL_LAST = XW'(IMG_W - 1);
    localparam logic [YW-1:0] ROW_LAST = YW'(IMG_H - 1);
    localparam logic [XW-1:0] COL_WIN  = XW'(K - 1);
    localparam logic [YW-1:0] ROW_WIN  = YW'(K - 1);
    localparam logic [NW-1:0] C_LAST   = NW'(NC - 1);

    localparam logic signed [CW-1:0] RES_MAX = {{(CW-RES_W+1){1'b0}}, {(RES_W-1){1'b1}}};
    localparam logic signed [CW-1:0] RES_MIN = {{(CW-RES_W+1){1'b1}}, {(RES_W-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, LOAD_FLT, STREAM, DRAIN} state_t;

    state_t                   state, state_nxt;
    logic [XW-1:0]            col;
    logic [YW-1:0]            row;
    logic [NW-1:0]            cidx;
    logic signed [FLT_W-1:0]  coef    [NC];
    logic signed [IN_W:0]     lb      [K-1][IMG_W];
    logic signed [IN_W:0]     win     [K][K];
    logic signed [IN_W:0]     win_nxt [K][K];
    logic signed [IN_W:0]     colv    [K];
    logic signed [IN_W:0]     pix_x;
    logic signed [PW-1:0]     prod    [NC];
    logic signed [SW-1:0]     sum;
    logic signed [CW-1:0]     sum_x, clip;
    logic                     s1_valid, s1_last;
    logic                     res_valid_q, res_last_q;
    logic [RES_W-1:0]         res_data_q;
    logic                     advance, pix_ready_w, pix_acc, flt_acc, win_done, pix_last;

    assign advance       = !res_valid_q || bus.res_ready;
    assign pix_ready_w   = (state == STREAM) && advance;
    assign pix_acc       = bus.pix_valid && pix_ready_w;
    assign flt_acc       = bus.flt_valid && (state == LOAD_FLT);
    assign win_done      = (row >= ROW_WIN) && (col >= COL_WIN);
    assign pix_last      = (row == ROW_LAST) && (col == COL_LAST);
    assign pix_x         = (IN_SIGNED != 0) ? {bus.pix_data[IN_W-1], bus.pix_data}
                                            : {1'b0, bus.pix_data};

    assign bus.flt_ready = (state == LOAD_FLT);
    assign bus.pix_ready = pix_ready_w;
    assign bus.res_valid = res_valid_q;
    assign bus.res_data  = res_data_q;
    assign bus.res_last  = res_last_q;
    assign busy          = (state != IDLE);

    // The incoming pixel joins the K-1 buffered pixels above it to form the new window column.
    always_comb begin
        for (int r = 0; r < K - 1; r++) begin
            colv[r] = lb[r][col];
        end
        colv[K-1] = pix_x;
        for (int r = 0; r < K; r++) begin
            for (int c = 0; c < K - 1; c++) begin
                win_nxt[r][c] = win[r][c+1];
            end
            win_nxt[r][K-1] = colv[r];
        end
    end

    always_ff @(posedge clk) begin
        if (pix_acc) begin
            for (int r = 0; r < K - 1; r++) begin
                lb[r][col] <= colv[r+1];
            end
            win <= win_nxt;
            for (int r = 0; r < K; r++) begin
                for (int c = 0; c < K; c++) begin
                    prod[r*K+c] <= PW'(win_nxt[r][c]) * PW'(coef[r*K+c]);
                end
            end
        end
    end

    // ReLU acts on the full-width sum, before saturation to the output range.
    always_comb begin
        sum = '0;
        for (int i = 0; i < NC; i++) begin
            sum = sum + SW'(prod[i]);
        end
        sum_x = {{(CW-SW){sum[SW-1]}}, sum};
        if ((RELU != 0) && sum_x[CW-1]) begin
            clip = '0;
        end else if (sum_x > RES_MAX) begin
            clip = RES_MAX;
        end else if (sum_x < RES_MIN) begin
            clip = RES_MIN;
        end else begin
            clip = sum_x;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid    <= 1'b0;
            s1_last     <= 1'b0;
            res_valid_q <= 1'b0;
            res_last_q  <= 1'b0;
            res_data_q  <= '0;
        end else if (advance) begin
            s1_valid    <= pix_acc && win_done;
            s1_last     <= pix_acc && pix_last;
            res_valid_q <= s1_valid;
            res_last_q  <= s1_valid && s1_last;
            if (s1_valid) begin
                res_data_q <= clip[RES_W-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            col   <= '0;
            row   <= '0;
            cidx  <= '0;
            for (int i = 0; i < NC; i++) begin
                coef[i] <= '0;
            end
        end else begin
            state <= state_nxt;
            if (flt_acc) begin
                coef[cidx] <= bus.flt_data;
                cidx       <= (cidx == C_LAST) ? '0 : cidx + 1'b1;
            end
            if (pix_acc) begin
                if (col == COL_LAST) begin
                    col <= '0;
                    row <= (row == ROW_LAST) ? '0 : row + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end
            end
        end
    end

    always_comb begin
        state_nxt = state;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = reuse_flt ? STREAM : LOAD_FLT;
                end
            end
            LOAD_FLT: begin
                if (flt_acc && (cidx == C_LAST)) begin
                    state_nxt = STREAM;
                end
            end
            STREAM: begin
                if (pix_acc && pix_last) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (res_valid_q && res_last_q && bus.res_ready) begin
                    done      = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end
endmodule

// File: tb/tb_conv2d_stream_layer.sv
// tb/tb_conv2d_stream_layer.sv - directed bench for conv2d_stream_layer
module tb_conv2d_stream_layer;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, start, reuse_flt;
    logic busy_a, done_a, busy_b, done_b, busy_c, done_c;

    conv2d_stream_layer_if #(.IN_W(8), .FLT_W(4), .RES_W(14)) ia ();
    conv2d_stream_layer_if #(.IN_W(8), .FLT_W(4), .RES_W(14)) ib ();
    conv2d_stream_layer_if #(.IN_W(8), .FLT_W(4), .RES_W(6))  ic ();

    assign ib.flt_valid = ia.flt_valid;
    assign ib.flt_data  = ia.flt_data;
    assign ib.pix_valid = ia.pix_valid;
    assign ib.pix_data  = ia.pix_data;
    assign ib.res_ready = ia.res_ready;
    assign ic.flt_valid = ia.flt_valid;
    assign ic.flt_data  = ia.flt_data;
    assign ic.pix_valid = ia.pix_valid;
    assign ic.pix_data  = ia.pix_data;
    assign ic.res_ready = ia.res_ready;

    conv2d_stream_layer #(.IN_W(8), .IN_SIGNED(0), .FLT_W(4), .K(3), .IMG_W(4), .IMG_H(4),
                          .RES_W(14), .RELU(0)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start), .reuse_flt(reuse_flt),
        .bus(ia), .busy(busy_a), .done(done_a));
    conv2d_stream_layer #(.IN_W(8), .IN_SIGNED(0), .FLT_W(4), .K(3), .IMG_W(4), .IMG_H(4),
                          .RES_W(14), .RELU(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start), .reuse_flt(reuse_flt),
        .bus(ib), .busy(busy_b), .done(done_b));
    conv2d_stream_layer #(.IN_W(8), .IN_SIGNED(0), .FLT_W(4), .K(3), .IMG_W(4), .IMG_H(4),
                          .RES_W(6), .RELU(0)) dut_c (
        .clk(clk), .rst_n(rst_n), .start(start), .reuse_flt(reuse_flt),
        .bus(ic), .busy(busy_c), .done(done_c));

    int   tests = 0;
    int   fails = 0;
    int   n_res, done_cnt, flt_seen;
    int   res_a [8];
    int   res_b [8];
    int   res_c [8];
    logic last_a [8];
    int   exp_pos [4] = '{54, 63, 90, 99};
    int   exp_reu [4] = '{63, 72, 99, 108};

    // Inputs only change on the falling edge, so +2 after it reflects what the next rising edge sees.
    always @(negedge clk) begin
        #2;
        if (ia.res_valid && ia.res_ready && n_res < 8) begin
            res_a[n_res]  = $signed(ia.res_data);
            res_b[n_res]  = $signed(ib.res_data);
            res_c[n_res]  = $signed(ic.res_data);
            last_a[n_res] = ia.res_last;
            n_res++;
        end
        if (done_a) done_cnt++;
        if (ia.flt_ready) flt_seen++;
    end

    task automatic chk(input string tag, input int obs, input int expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, expv);
        end
    endtask

    task automatic start_frame(input logic reuse);
        n_res = 0;
        done_cnt = 0;
        flt_seen = 0;
        for (int i = 0; i < 8; i++) last_a[i] = 1'b0;
        start = 1'b1;
        reuse_flt = reuse;
        @(negedge clk);
        start = 1'b0;
        reuse_flt = 1'b0;
    endtask

    task automatic send_flt(input int v);
        int n = 0;
        ia.flt_valid = 1'b1;
        ia.flt_data = 4'(v);
        #1;
        while (!ia.flt_ready && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("flt_ready_wait", int'(ia.flt_ready), 1);
        @(negedge clk);
        ia.flt_valid = 1'b0;
    endtask

    task automatic load_flt(input int v);
        for (int i = 0; i < 9; i++) send_flt(v);
    endtask

    task automatic send_pix(input int v);
        int n = 0;
        ia.pix_valid = 1'b1;
        ia.pix_data = 8'(v);
        #1;
        while (!ia.pix_ready && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("pix_ready_wait", int'(ia.pix_ready), 1);
        @(negedge clk);
        ia.pix_valid = 1'b0;
    endtask

    task automatic send_img(input int base, input int cnt);
        for (int i = 0; i < cnt; i++) send_pix(base + i);
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((busy_a || n_res < 4) && n < 100) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        @(negedge clk);
        chk("frame_end_busy", int'(busy_a), 0);
    endtask

    task automatic chk_meta(input string tag);
        chk({tag, "_count"}, n_res, 4);
        chk({tag, "_last_early"}, int'(last_a[0]) + int'(last_a[1]) + int'(last_a[2]), 0);
        chk({tag, "_last_final"}, int'(last_a[3]), 1);
        chk({tag, "_done"}, done_cnt, 1);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_res_valid"}, int'(ia.res_valid), 0);
        chk({tag, "_res_data"}, int'(ia.res_data), 0);
        chk({tag, "_res_last"}, int'(ia.res_last), 0);
        chk({tag, "_pix_ready"}, int'(ia.pix_ready), 0);
        chk({tag, "_flt_ready"}, int'(ia.flt_ready), 0);
        chk({tag, "_busy"}, int'(busy_a), 0);
        chk({tag, "_done"}, int'(done_a), 0);
    endtask

    initial begin
        rst_n = 1'b1;
        start = 1'b0;
        reuse_flt = 1'b0;
        ia.flt_valid = 1'b0;
        ia.flt_data = '0;
        ia.pix_valid = 1'b0;
        ia.pix_data = '0;
        ia.res_ready = 1'b1;
        n_res = 0;
        done_cnt = 0;
        flt_seen = 0;
        #2 rst_n = 1'b0;
        #1 chk_reset_outputs("rst");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // All +1 coefficients; RELU passes positives, RES_W=6 saturates high.
        start_frame(1'b0);
        load_flt(1);
        send_img(1, 16);
        wait_idle();
        for (int i = 0; i < 4; i++) begin
            chk("pos_a", res_a[i], exp_pos[i]);
            chk("pos_relu", res_b[i], exp_pos[i]);
            chk("pos_sat", res_c[i], 31);
        end
        chk_meta("pos");

        // All -1 coefficients.
        start_frame(1'b0);
        load_flt(-1);
        send_img(1, 16);
        wait_idle();
        for (int i = 0; i < 4; i++) begin
            chk("neg_a", res_a[i], -exp_pos[i]);
            chk("neg_relu", res_b[i], 0);
            chk("neg_sat", res_c[i], -32);
        end
        chk_meta("neg");

        // Back-pressure for 5 cycles on the first result.
        start_frame(1'b0);
        load_flt(1);
        fork
            send_img(1, 16);
            begin
                int n = 0;
                @(negedge clk);
                while (!ia.res_valid && n < 100) begin
                    @(negedge clk);
                    n++;
                end
                ia.res_ready = 1'b0;
                for (int i = 0; i < 5; i++) begin
                    #1;
                    chk("stall_pix_ready", int'(ia.pix_ready), 0);
                    chk("stall_res_valid", int'(ia.res_valid), 1);
                    chk("stall_res_data", $signed(ia.res_data), 54);
                    @(negedge clk);
                end
                ia.res_ready = 1'b1;
            end
        join
        wait_idle();
        for (int i = 0; i < 4; i++) chk("stall_a", res_a[i], exp_pos[i]);
        chk_meta("stall");

        // Reuse stored coefficients with pixels 2..17.
        start_frame(1'b1);
        send_img(2, 16);
        wait_idle();
        for (int i = 0; i < 4; i++) begin
            chk("reuse_a", res_a[i], exp_reu[i]);
            chk("reuse_sat", res_c[i], 31);
        end
        chk("reuse_flt_ready", flt_seen, 0);
        chk_meta("reuse");

        // Reset after the 10th pixel.
        start_frame(1'b0);
        load_flt(1);
        send_img(1, 10);
        chk("pre_rst_busy", int'(busy_a), 1);
        rst_n = 1'b0;
        #1 chk_reset_outputs("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Reset cleared the coefficient store.
        start_frame(1'b1);
        send_img(1, 16);
        wait_idle();
        for (int i = 0; i < 4; i++) chk("cleared_a", res_a[i], 0);

        start_frame(1'b0);
        load_flt(1);
        send_img(1, 16);
        wait_idle();
        for (int i = 0; i < 4; i++) chk("after_rst_a", res_a[i], exp_pos[i]);
        chk_meta("after_rst");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/conv2d_stream_layer.md
Name: conv2d_stream_layer

Overview:
- Parametrised single convolution layer: KxK filter, stride 1, "valid" 2-D convolution over an IMG_W x IMG_H image streamed in raster order.
- Adds valid/ready flow control, optional ReLU, output saturation, and filter reuse across images.
- Instances chain directly: one instance's res_* stream feeds the next instance's pix_* stream, so multi-layer CNNs need no glue logic.

Parameters:
- IN_W, 4: pixel width. Unsigned when IN_SIGNED=0, else two's complement.
- IN_SIGNED, 0: 1 = pixels are signed.
- FLT_W, 4: filter coefficient width, always signed.
- K, 3: kernel edge (2..5).
- IMG_W, 4: image columns (K..64).
- IMG_H, 4: image rows (K..64).
- RES_W, 14: output width. Results saturate to the signed RES_W range.
- RELU, 0: 1 = negative results are forced to 0 before output.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle request to begin a frame
- reuse_flt  in  1  sampled with start. 1 = skip filter load and use the stored coefficients.
- flt_valid  in  1  coefficient present on flt_data
- flt_data  in  FLT_W  signed coefficient, row-major order
- flt_ready  out  1  high in LOAD_FLT
- pix_valid  in  1  pixel present on pix_data
- pix_data  in  IN_W  pixel, raster order
- pix_ready  out  1  pixel accepted when pix_valid && pix_ready
- res_valid  out  1  result valid
- res_data  out  RES_W  signed result
- res_last  out  1  marks the final result of the frame
- res_ready  in  1  downstream accept
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse after the last result is accepted

Behaviour:
- Reset (async, rst_n=0): state=IDLE. Row/column/coefficient counters=0. Pipeline valid bits=0. Outputs: flt_ready=0, pix_ready=0, res_valid=0, res_data=0, res_last=0, busy=0, done=0. Coefficient RAM is cleared to 0.
- FSM:
  - IDLE: on start, go to LOAD_FLT, or to STREAM if reuse_flt=1. start is ignored in every state other than IDLE.
  - LOAD_FLT: accept K*K coefficients on flt_valid && flt_ready. After the last one, go to STREAM next cycle.
  - STREAM: accept IMG_W*IMG_H pixels. After the last pixel is accepted, go to DRAIN.
  - DRAIN: wait until the pipeline is empty and the final result is accepted. Then pulse done and return to IDLE.
- Windowing:
  - K-1 line buffers of IMG_W entries, plus a KxK window register.
  - A window is complete when the accepted pixel has row >= K-1 and col >= K-1.
  - Number of results = (IMG_W-K+1)*(IMG_H-K+1), emitted in raster order.
  - Windows that wrap across a row boundary are never emitted.
- Arithmetic:
  - Pixels are extended to IN_W+1 signed bits (zero-extended if unsigned, sign-extended if signed).
  - K*K products are summed at full width: IN_W+1+FLT_W+ceil(log2(K*K)) bits.
  - Then ReLU is applied (if RELU=1), then the result saturates to [-2^(RES_W-1), 2^(RES_W-1)-1].
- Pipeline and latency:
  - Stage 1 registers the products. Stage 2 registers the sum/ReLU/saturation into res_data.
  - res_valid rises 2 cycles after the completing pixel is accepted, with no stalls.
- Flow control:
  - The pipeline advances when !res_valid || res_ready.
  - pix_ready = (state==STREAM) && advance.
  - res_data, res_valid and res_last hold steady while res_valid && !res_ready.
  - Throughput is one pixel per cycle.
- res_last is asserted together with the final window's result.
- Coefficients persist across frames until the next LOAD_FLT or reset.
- Boundaries:
  - flt_valid outside LOAD_FLT is ignored.
  - pix_valid outside STREAM is ignored.
  - start coinciding with the done pulse is ignored, because the state is still DRAIN.
  - Reset mid-frame discards all partial data.

Test Plan:
- K=3, 4x4 image with pixels 1..16, all coefficients +1, RES_W=14 -> results 54, 63, 90, 99. res_last on 99. done pulses once.
- Same image, all coefficients -1: RELU=0 -> -54, -63, -90, -99. RELU=1 -> 0, 0, 0, 0.
- RES_W=6, all coefficients +1 -> every result saturates to 31. With coefficients -1 and RELU=0 -> -32.
- Hold res_ready=0 for 5 cycles when the first result appears -> pix_ready=0 throughout, res_data held at 54. Release -> remaining results are correct and in order.
- Second frame with reuse_flt=1 and pixels 2..17 -> no flt_ready. Results 63, 72, 99, 108.
- Assert rst_n=0 after the 10th pixel -> all outputs zero immediately. A new frame after reset reproduces the first scenario exactly.
